fb_writer: RTL and testbench

FB_WRITER -- requirements
Module: fb_writer

---
 rtl/color_pkg.sv | 7 +
 rtl/fb_pkg.sv | 13 +
 rtl/fb_addr_calc.sv | 21 ++
 rtl/fb_writer.sv | 129 ++++++++++++
 tb/tb_fb_writer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/color_pkg.sv
// Shared pixel colour types.
//   color16_t : 16-bit RGB565 pixel (R[15:11], G[10:5], B[4:0]).
package color_pkg;

  typedef logic [15:0] color16_t;

endpackage

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry.
//   FB_WIDTH / FB_HEIGHT : default framebuffer size in pixels.
//   FB_ADDR_W            : write address width able to cover FB_WIDTH*FB_HEIGHT.
//   fb_addr_t            : framebuffer word address.
package fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_ADDR_W = 17;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational row-major framebuffer address: o_addr = i_y*WIDTH + i_x.
// Kept separate so the multiply can be swapped for a shift-add tree when
// WIDTH is a convenient constant (e.g. 320 = 256 + 64).
// Ports:
//   i_x    : pixel column (assumed < WIDTH)
//   i_y    : pixel row    (assumed < HEIGHT)
//   o_addr : linear address, ADDR_W bits
module fb_addr_calc #(
  parameter int WIDTH  = 320,
  parameter int ADDR_W = 17
) (
  input  logic [15:0]       i_x,
  input  logic [15:0]       i_y,
  output logic [ADDR_W-1:0] o_addr
);

  // With x < WIDTH and y < HEIGHT the result is below WIDTH*HEIGHT, which
  // fits in ADDR_W bits, so doing the arithmetic at ADDR_W cannot overflow.
  assign o_addr = ADDR_W'(i_y) * ADDR_W'(WIDTH) + ADDR_W'(i_x);

endmodule

// File: rtl/fb_writer.sv
// Framebuffer pixel writer: accepts (x, y, colour) beats over a valid/ready
// handshake, drops off-screen pixels and issues one framebuffer write per
// on-screen pixel, in order, through a two-stage pipeline.
//   S1: registers the incoming beat and flags it as clipped if off-screen.
//   S2: holds the write address/data and drives mem_* until granted.
// Optional build macro FB_WRITER_CLIP_COUNT_EN adds clip_count, a
// saturating count of dropped pixels.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_pixel_x/_y         : pixel coordinates, unsigned
//   in_color              : RGB565 data
//   in_valid / in_ready   : upstream handshake
//   mem_addr / mem_data   : framebuffer write address / data
//   mem_we / mem_ready    : write strobe / memory grant
//   clip_count            : dropped pixel count (FB_WRITER_CLIP_COUNT_EN only)
//   busy                  : any pipeline stage holds a pixel
module fb_writer
  import color_pkg::*;
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDR_W = FB_ADDR_W   // 2**ADDR_W must be >= WIDTH*HEIGHT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       in_pixel_x,
  input  logic [15:0]       in_pixel_y,
  input  color16_t          in_color,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output color16_t          mem_data,
  output logic              mem_we,
  input  logic              mem_ready,
`ifdef FB_WRITER_CLIP_COUNT_EN
  output logic [15:0]       clip_count,
`endif
  output logic              busy
);

  logic              r_s1_valid;
  logic [15:0]       r_s1_x;
  logic [15:0]       r_s1_y;
  color16_t          r_s1_color;

  logic              r_s2_valid;
  logic [ADDR_W-1:0] r_s2_addr;
  color16_t          r_s2_data;

  logic              w_accept;
  logic              w_s1_drop;
  logic              w_s1_advance;
  logic              w_s2_commit;
  logic [ADDR_W-1:0] w_s1_addr;

  assign w_s2_commit  = r_s2_valid && mem_ready;
  assign w_s1_drop    = (32'(r_s1_x) >= WIDTH) || (32'(r_s1_y) >= HEIGHT);
  // A clipped pixel never needs S2, so it can leave S1 even during a stall.
  assign w_s1_advance = r_s1_valid && (w_s1_drop || !r_s2_valid || w_s2_commit);
  assign in_ready     = !r_s1_valid || w_s1_advance;
  assign w_accept     = in_valid && in_ready;

  // ---- S1: input register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
    end else if (w_s1_advance) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Payload only matters when r_s1_valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_x     <= in_pixel_x;
      r_s1_y     <= in_pixel_y;
      r_s1_color <= in_color;
    end
  end

  fb_addr_calc #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .i_x    (r_s1_x),
    .i_y    (r_s1_y),
    .o_addr (w_s1_addr)
  );

  // ---- S2: write register ----
  // Address/data are reset too so the memory bus reads zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_data  <= '0;
    end else if (w_s1_advance && !w_s1_drop) begin
      // Refill in the same cycle as a commit, so no bubble is inserted.
      r_s2_valid <= 1'b1;
      r_s2_addr  <= w_s1_addr;
      r_s2_data  <= r_s1_color;
    end else if (w_s2_commit) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign mem_we   = r_s2_valid;
  assign mem_addr = r_s2_addr;
  assign mem_data = r_s2_data;
  assign busy     = r_s1_valid || r_s2_valid;

`ifdef FB_WRITER_CLIP_COUNT_EN
  logic [15:0] r_clip_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clip_count <= '0;
    end else if (w_s1_advance && w_s1_drop && (r_clip_count != 16'hFFFF)) begin
      r_clip_count <= r_clip_count + 16'd1;
    end
  end

  assign clip_count = r_clip_count;
`endif

endmodule

// File: tb/tb_fb_writer.sv
module tb_fb_writer;
  import color_pkg::*;

  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_pixel_x;
  logic [15:0] in_pixel_y;
  color16_t    in_color;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] mem_addr;
  color16_t    mem_data;
  logic        mem_we;
  logic        mem_ready;
  logic        busy;
`ifdef FB_WRITER_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int commits  = 0;
  int stalls   = 0;
  int cyc      = 0;
  bit win      = 1'b0;
  int win_n    = 0;
  int win_first = 0;
  int win_last  = 0;
  wr_t sb[$];

  fb_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_pixel_x (in_pixel_x),
    .in_pixel_y (in_pixel_y),
    .in_color   (in_color),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
`ifdef FB_WRITER_CLIP_COUNT_EN
    .clip_count (clip_count),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every committed write must match the next expected one, in order.
  always @(posedge clk) begin
    cyc++;
    if (mem_we && mem_ready) begin
      commits++;
      if (win) begin
        if (win_n == 0) win_first = cyc;
        win_last = cyc;
        win_n++;
      end
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL unexpected_write: observed write addr=%0d, expected no write", mem_addr);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_data), 32'(e.data));
      end
    end
  end

  task automatic send(input int x, input int y, input logic [15:0] c);
    int t;
    t = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    in_pixel_x = 16'(x);
    in_pixel_y = 16'(y);
    in_color   = c;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t > 0) stalls++;
    if (t >= 50) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
    end else if (x < 320 && y < 240) begin
      sb.push_back({17'(y * 320 + x), c});
    end
    @(posedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 32'(t < 100), 32'd1);
  endtask

  initial begin
    int p;
    rst_n = 1'b0; in_valid = 1'b0; in_pixel_x = '0; in_pixel_y = '0;
    in_color = '0; mem_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single pixel, 2-cycle latency
    send(0, 0, 16'hF800);
    @(negedge clk); in_valid = 1'b0;
    chk("lat_we_c1", 32'(mem_we), 32'd0);
    chk("lat_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_we_c2", 32'(mem_we), 32'd1);
    chk("lat_addr", 32'(mem_addr), 32'd0);
    chk("lat_data", 32'(mem_data), 32'h0000F800);
    @(negedge clk);
    chk("lat_we_after", 32'(mem_we), 32'd0);
    chk("lat_busy_after", 32'(busy), 32'd0);

    // Full frame back-to-back
    p = commits; stalls = 0; win = 1'b1; win_n = 0;
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 320; x++)
        send(x, y, 16'(x ^ (y << 8)));
    @(negedge clk); in_valid = 1'b0;
    chk("frame_busy_c0", 32'(busy), 32'd1);
    @(negedge clk);
    chk("frame_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("frame_busy_c2", 32'(busy), 32'd0);
    win = 1'b0;
    chk("frame_writes", 32'(commits - p), 32'd76800);
    chk("frame_stalls", 32'(stalls), 32'd0);
    chk("frame_bubbles", 32'(win_last - win_first + 1 - win_n), 32'd0);
    chk("frame_sb_empty", 32'(sb.size()), 32'd0);

    // Clipping
    p = commits;
    send(320, 5, 16'h0001);
    send(10, 240, 16'h0002);
    send(319, 239, 16'h0003);
    @(negedge clk); in_valid = 1'b0;
    wait_idle();
    chk("clip_writes", 32'(commits - p), 32'd1);
    chk("clip_sb_empty", 32'(sb.size()), 32'd0);
`ifdef FB_WRITER_CLIP_COUNT_EN
    chk("clip_count", 32'(clip_count), 32'd2);
`endif

    // Backpressure: mem_ready low for the first 4 mem_we cycles
    p = commits;
    mem_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_pixel_x = 16'd5; in_pixel_y = 16'd1; in_color = 16'h1111;
    #1 chk("bp_rdy0", 32'(in_ready), 32'd1);
    sb.push_back({17'd325, 16'h1111});
    @(posedge clk);
    @(negedge clk);
    in_pixel_x = 16'd6; in_color = 16'h2222;
    #1 chk("bp_rdy1", 32'(in_ready), 32'd1);
    sb.push_back({17'd326, 16'h2222});
    @(posedge clk);
    @(negedge clk);
    in_pixel_x = 16'd7; in_color = 16'h3333;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("bp_we", 32'(mem_we), 32'd1);
      chk("bp_addr_hold", 32'(mem_addr), 32'd325);
      chk("bp_data_hold", 32'(mem_data), 32'h1111);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("bp_rdy_release", 32'(in_ready), 32'd1);
    chk("bp_addr_release", 32'(mem_addr), 32'd325);
    sb.push_back({17'd327, 16'h3333});
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    chk("bp_addr_2", 32'(mem_addr), 32'd326);
    @(negedge clk);
    chk("bp_addr_3", 32'(mem_addr), 32'd327);
    @(negedge clk);
    chk("bp_busy_end", 32'(busy), 32'd0);
    chk("bp_writes", 32'(commits - p), 32'd3);

    // Reset with two pixels in flight
    mem_ready = 1'b0;
    send(10, 10, 16'h4444);
    send(11, 10, 16'h5555);
    @(negedge clk); in_valid = 1'b0;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    chk("mid_we_pre", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_we", 32'(mem_we), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_addr", 32'(mem_addr), 32'd0);
    chk("mid_data", 32'(mem_data), 32'd0);
    sb.delete();
    p = commits;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_no_write", 32'(commits - p), 32'd0);
`ifdef FB_WRITER_CLIP_COUNT_EN
    chk("mid_clip_count", 32'(clip_count), 32'd0);
`endif

    // First accept after reset behaves as after power-up
    send(3, 2, 16'h07E0);
    @(negedge clk); in_valid = 1'b0;
    chk("post_we_c1", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("post_we_c2", 32'(mem_we), 32'd1);
    chk("post_addr", 32'(mem_addr), 32'd643);
    chk("post_data", 32'(mem_data), 32'h07E0);
    @(negedge clk);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_writes", 32'(commits - p), 32'd1);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
